count_direction_decoder: RTL
============================

COUNT_DIRECTION_DECODER -- requirements
Module: count_direction_decoder

Interface
REQ-001 Parameter ERR_W, default 4: width of the saturating error counter, legal range 2..8.
REQ-002 Parameter STRICT, default 0: when 1, a zero step (stall) is classified as an error.
REQ-003 clock  in  1  sole clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 enable  in  1  qualifies count as a valid sample this cycle.
REQ-006 count  in  3  observed value from a 0..7 up/down counter.
REQ-007 direction  out  1  decoded direction: 0 = up, 1 = down; same encoding as the counter's direction input.
REQ-008 locked  out  1  high while the direction is established (state UP or DOWN).
REQ-009 position  out  3  last accepted sample.
REQ-010 wrap  out  1  one-cycle pulse on a 7->0 up step or a 0->7 down step.
REQ-011 reversal  out  1  one-cycle pulse when a locked direction flips.
REQ-012 stall  out  1  one-cycle pulse on a zero step.
REQ-013 error  out  1  one-cycle pulse on an illegal step.
REQ-014 error_count  out  ERR_W  saturating count of error pulses.

Function
REQ-015 Step is computed as (count - position) mod 8 and classified as: 1 = UPSTEP; 7 = DOWNSTEP; 0 = ZERO; 2..6 = ILLEGAL.
REQ-016 ZERO shall be ILLEGAL when STRICT=1 and STALL otherwise.
REQ-017 FSM states are INIT, ACQUIRE, UP and DOWN.
REQ-018 With enable=0, state, position, direction and error_count shall hold, and all pulses shall be 0.
REQ-019 INIT with enable: store count in position and go to ACQUIRE; no pulse.
REQ-020 ACQUIRE with enable:
- UPSTEP: go to UP, direction=0.
- DOWNSTEP: go to DOWN, direction=1.
- STALL: stay.
- ILLEGAL: stay and pulse error.
REQ-021 UP with enable:
- UPSTEP: stay.
- DOWNSTEP: go to DOWN, direction=1, pulse reversal.
- STALL: stay.
- ILLEGAL: go to ACQUIRE and pulse error.
REQ-022 DOWN is symmetric to UP: DOWNSTEP stays; UPSTEP goes to UP with direction=0 and pulses reversal.
REQ-023 In every state except INIT, each enabled sample shall update position to count.
REQ-024 wrap shall pulse on UPSTEP from 7 to 0 and on DOWNSTEP from 0 to 7, in any non-INIT state including ACQUIRE; wrap and reversal may assert in the same cycle.
REQ-025 Latency: all outputs are registered and reflect the sample taken at edge N from edge N onward; pulses last exactly one cycle.
REQ-026 error_count shall increment on each error pulse and saturate at 2^ERR_W-1, with no wrap.
REQ-027 direction shall hold its last decided value outside UP/DOWN.
REQ-028 locked shall be high exactly when the state is UP or DOWN.

Reset
REQ-029 reset overrides enable; on the next edge: state=INIT, position=0, direction=0, locked=0, all pulses=0, error_count=0.
REQ-030 reset asserted mid-sequence shall discard history; the first enabled sample after reset only re-acquires and produces no pulse.

Structure
REQ-031 The state encoding (INIT=0, ACQUIRE=1, UP=2, DOWN=3), the count width constant 3 and the step-class codes shall live in a shared package/include.
REQ-032 One combinational sub-module, step_classifier, shall map (position, count, STRICT) to a step class and a wrap flag; the FSM and counters remain in count_direction_decoder.

Verification
REQ-033 Scenario 1: reset, then enable with count 3,4,5,6,7,0,1.
- locked rises after the sample 4.
- direction=0.
- wrap pulses once, at 7->0.
- error_count=0.
REQ-034 Scenario 2: count 2,1,0,7,6 with enable.
- direction=1, locked=1.
- wrap pulses once, at 0->7.
REQ-035 Scenario 3: count 5,6,7,6.
- reversal pulses on the last sample.
- direction goes 0->1.
- locked stays 1.
REQ-036 Scenario 4: count 1,2,5.
- error pulses once.
- state goes to ACQUIRE, locked=0.
- position=5.
- error_count=1.
REQ-037 Scenario 5: count 4,4 with STRICT=0, then STRICT=1.
- STRICT=0: stall pulses, no error.
- STRICT=1: error pulses.
- Also drive 20 illegal steps with ERR_W=4: error_count saturates at 15.
REQ-038 Scenario 6: count 0,1,2, then reset together with enable and count 3, then count 4.
- After the reset edge: all outputs are at reset values.
- The sample 4 only re-acquires: no pulses, locked=0.

Source files
------------

// File: rtl/count_direction_decoder_pkg.sv
// Shared types and constants for the count direction decoder.
// The state encoding and step-class codes are shared by the FSM and the step classifier.
package count_direction_decoder_pkg;

    localparam int COUNT_W = 3;

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_UP      = 2'd2,
        ST_DOWN    = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        STEP_UP      = 2'd0,
        STEP_DOWN    = 2'd1,
        STEP_STALL   = 2'd2,
        STEP_ILLEGAL = 2'd3
    } step_class_t;

endpackage

// File: rtl/count_direction_decoder_step_classifier.sv
// Purely combinational step classifier.
// It classifies the modulo-8 difference between a new sample and the last accepted position.
module step_classifier
    import count_direction_decoder_pkg::*;
#(
    parameter int STRICT = 0
) (
    input  logic [COUNT_W-1:0] i_position,
    input  logic [COUNT_W-1:0] i_count,
    output step_class_t        o_class,
    output logic               o_wrap
);

    logic [COUNT_W-1:0] w_step;

    assign w_step = i_count - i_position;

    always_comb begin
        o_class = STEP_ILLEGAL;
        case (w_step)
            3'd1:    o_class = STEP_UP;
            3'd7:    o_class = STEP_DOWN;
            // A repeated value is a stall, unless strict mode treats it as an error.
            3'd0:    o_class = (STRICT != 0) ? STEP_ILLEGAL : STEP_STALL;
            default: o_class = STEP_ILLEGAL;
        endcase
    end

    assign o_wrap = ((o_class == STEP_UP)   && (i_position == 3'd7)) ||
                    ((o_class == STEP_DOWN) && (i_position == 3'd0));

endmodule

// File: rtl/count_direction_decoder.sv
// Tracks an up/down counter's output and infers its direction.
// It also reports wraps, reversals, stalls and illegal jumps.
module count_direction_decoder
    import count_direction_decoder_pkg::*;
#(
    parameter int ERR_W  = 4,
    parameter int STRICT = 0
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic [COUNT_W-1:0] i_count,
    output logic               o_direction,
    output logic               o_locked,
    output logic [COUNT_W-1:0] o_position,
    output logic               o_wrap,
    output logic               o_reversal,
    output logic               o_stall,
    output logic               o_error,
    output logic [ERR_W-1:0]   o_error_count
);

    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    state_t             r_state;
    logic [COUNT_W-1:0] r_position;
    logic               r_direction;
    logic               r_wrap;
    logic               r_reversal;
    logic               r_stall;
    logic               r_error;
    logic [ERR_W-1:0]   r_errorCount;

    state_t      w_nextState;
    logic        w_nextDirection;
    step_class_t w_class;
    logic        w_stepWrap;
    logic        w_active;
    logic        w_wrapNext;
    logic        w_reversalNext;
    logic        w_stallNext;
    logic        w_errorNext;

    step_classifier #(
        .STRICT(STRICT)
    ) u_classifier (
        .i_position(r_position),
        .i_count   (i_count),
        .o_class   (w_class),
        .o_wrap    (w_stepWrap)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= ST_INIT;
            r_position   <= '0;
            r_direction  <= 1'b0;
            r_wrap       <= 1'b0;
            r_reversal   <= 1'b0;
            r_stall      <= 1'b0;
            r_error      <= 1'b0;
            r_errorCount <= '0;
        end else begin
            r_state     <= w_nextState;
            r_direction <= w_nextDirection;
            r_wrap      <= w_wrapNext;
            r_reversal  <= w_reversalNext;
            r_stall     <= w_stallNext;
            r_error     <= w_errorNext;
            if (i_enable) begin
                r_position <= i_count;
            end
            if (w_errorNext && (r_errorCount != ERR_MAX)) begin
                r_errorCount <= r_errorCount + ERR_W'(1);
            end
        end
    end

    always_comb begin
        w_nextState     = r_state;
        w_nextDirection = r_direction;
        if (i_enable) begin
            case (r_state)
                ST_INIT: w_nextState = ST_ACQUIRE;
                ST_ACQUIRE: begin
                    if (w_class == STEP_UP) begin
                        w_nextState     = ST_UP;
                        w_nextDirection = 1'b0;
                    end else if (w_class == STEP_DOWN) begin
                        w_nextState     = ST_DOWN;
                        w_nextDirection = 1'b1;
                    end
                end
                ST_UP: begin
                    if (w_class == STEP_DOWN) begin
                        w_nextState     = ST_DOWN;
                        w_nextDirection = 1'b1;
                    end else if (w_class == STEP_ILLEGAL) begin
                        w_nextState = ST_ACQUIRE;
                    end
                end
                ST_DOWN: begin
                    if (w_class == STEP_UP) begin
                        w_nextState     = ST_UP;
                        w_nextDirection = 1'b0;
                    end else if (w_class == STEP_ILLEGAL) begin
                        w_nextState = ST_ACQUIRE;
                    end
                end
                default: w_nextState = ST_INIT;
            endcase
        end
    end

    // The first sample after INIT only seeds the position, so it never raises a pulse.
    always_comb begin
        w_active       = i_enable && (r_state != ST_INIT);
        w_wrapNext     = w_active && w_stepWrap;
        w_stallNext    = w_active && (w_class == STEP_STALL);
        w_errorNext    = w_active && (w_class == STEP_ILLEGAL);
        w_reversalNext = w_active &&
                         (((r_state == ST_UP)   && (w_class == STEP_DOWN)) ||
                          ((r_state == ST_DOWN) && (w_class == STEP_UP)));
    end

    assign o_direction   = r_direction;
    assign o_locked      = (r_state == ST_UP) || (r_state == ST_DOWN);
    assign o_position    = r_position;
    assign o_wrap        = r_wrap;
    assign o_reversal    = r_reversal;
    assign o_stall       = r_stall;
    assign o_error       = r_error;
    assign o_error_count = r_errorCount;

endmodule
